// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment driver: latches a 32-bit value and scans its
// hex nibbles onto active-low anode/segment lines with a blanking gap per digit slot.
module seg7_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        blank_lz,
    output logic [7:0]  seg_out,
    output logic [7:0]  an_out
);

    localparam int                CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [31:0]       BLANK_U  = 32'(BLANK_CYC);

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    logic [31:0]      disp_q, disp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    state_t           state_q, state_d;
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       an_q, an_d;

    logic [4:0]       nib_lsb;
    logic [3:0]       nibble;
    logic             lz_hide;

    // The FSM state mirrors the slot position, so it is derived from the counter value
    // it will hold after this edge.
    function automatic state_t slot_state(input logic [CNT_W-1:0] c);
        return (32'(c) < BLANK_U) ? ST_BLANK : ST_DRIVE;
    endfunction

    function automatic logic [7:0] hex_decode(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_comb begin
        disp_d  = wr_en ? wr_data : disp_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
        state_d = slot_state(cnt_d);
    end

    // Digit idx is hidden under leading-zero suppression when every nibble from idx up is zero.
    always_comb begin
        nib_lsb = {idx_q, 2'b00};
        nibble  = disp_q[nib_lsb +: 4];
        lz_hide = blank_lz && (idx_q != 3'd0) && ((disp_q >> nib_lsb) == 32'd0);
        an_d    = 8'hFF;
        seg_d   = 8'hFF;
        if (state_q == ST_DRIVE && !lz_hide) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = hex_decode(nibble);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= slot_state('0);
            seg_q   <= 8'hFF;
            an_q    <= 8'hFF;
        end else begin
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg_out = seg_q;
    assign an_out  = an_q;

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed driver for the board's 8-digit seven-segment display. It sits directly downstream of the CPU's `digital` output (the MemOrIO write data). It latches the 32-bit value when the digital-write strobe fires, then scans the eight hex digits onto active-low segment and anode lines. It inserts a blanking gap between digits to prevent ghosting and can optionally suppress leading zeros.

## Interface
Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz). Must be ≥ 2 and > BLANK_CYC.
- BLANK_CYC, 2: cycles at the start of each slot with all anodes off. 0 disables blanking.

Ports:
- clk  in  1  system clock; same domain as the CPU clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  display-write strobe (DigitalCtrl qualified by IOWrite). Sampled on the rising edge of clk.
- wr_data  in  32  value to display (CPU `digital`). Nibble i drives digit i.
- blank_lz  in  1  1 = suppress leading zeros.
- seg_out  out  8  {dp,g,f,e,d,c,b,a}, active-low, registered.
- an_out  out  8  digit enables, active-low, registered. Bit 0 is the rightmost digit.

## Operation
- Display register `disp` loads wr_data at the edge where wr_en=1. It holds its value otherwise.
- Slot counter `cnt` counts 0..SCAN_DIV-1 and wraps to 0. On wrap, digit index `idx` (3 bits) increments, and 7 wraps to 0.
- Two-state FSM:
  - BLANK is active while cnt < BLANK_CYC.
  - DRIVE is active while cnt ≥ BLANK_CYC.
  - The state is a function of cnt; FSM transitions happen only on cnt changes.
- BLANK output: an_out=8'hFF, seg_out=8'hFF.
- DRIVE output: an_out has only bit idx low. seg_out = decode(disp[4*idx+3:4*idx]), with dp=1 (off).
- Decode table (hex, active-low incl. dp=1):
  - 0:C0 1:F9 2:A4 3:B0
  - 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83
  - C:C6 d:A1 E:86 F:8E
- Leading-zero suppression: when blank_lz=1, idx≠0, and disp[31:4*idx]==0, DRIVE outputs an_out=8'hFF and seg_out=8'hFF for that slot.
  - Digit 0 is always shown, so a value of 0 displays a single "0".
- blank_lz is sampled every cycle, not latched.

## Timing
- Reset values:
  - disp=0, cnt=0, idx=0.
  - an_out=8'hFF, seg_out=8'hFF.
- rst has priority over wr_en in the same cycle.
- Output latency: an_out and seg_out are registered from the current (cnt, idx, disp, blank_lz). A change in any of these is visible one clock later.
- Write latency: wr_en at edge N loads disp at edge N. The new digit pattern appears at edge N+1 if the current slot is in DRIVE.
- A write mid-slot takes effect immediately. The scan position is not restarted.
- Back-to-back wr_en: the last write wins, with no loss or queueing.
- Scan period: 8×SCAN_DIV cycles. Each digit is driven for SCAN_DIV−BLANK_CYC cycles per period.
- After reset release, outputs stay 8'hFF for 1+BLANK_CYC cycles, then digit 0 is driven.
- Reset asserted mid-slot: on the next edge, cnt/idx/disp clear and outputs go to 8'hFF. No partial-slot state survives.
- Exactly one anode is low at any time, or none. Two simultaneously low anodes are a failure.

## Test plan
Bench parameters: SCAN_DIV=4, BLANK_CYC=1.

1. Reset check: rst for 3 cycles, then release.
   - Required: an_out=FF and seg_out=FF during reset and on the first post-reset cycle.
   - Then an_out=FE and seg_out=C0 for 3 cycles.
   - Then FF for 1 cycle, then an_out=FD.
2. Full scan: write 32'h89AB_CDEF with blank_lz=0.
   - Required: over one 32-cycle period, digits 0..7 show 8E, 86, A1, C6, 83, 88, 90, 80.
   - Each digit is preceded by one all-FF cycle, on an_out FE, FD, FB, F7, EF, DF, BF, 7F.
3. Leading-zero suppression: write 32'h0000_0105 with blank_lz=1.
   - Required: digit 0 shows 92, digit 1 shows C0, digit 2 shows F9.
   - Digits 3–7 show an_out=FF for the whole slot.
   - Write 0: only digit 0 is driven (C0).
4. Mid-slot write: during a DRIVE cycle of digit 2, write 32'h0000_0700 (prior value 32'h0).
   - Required: seg_out changes from C0 to F8 exactly one cycle later.
   - an_out is unchanged and idx is not reset.
5. Reset vs write collision: assert rst and wr_en (32'hFFFF_FFFF) in the same cycle, mid-scan.
   - Required: disp=0, next outputs FF, and scan restarts at digit 0 showing C0.
6. Ghosting invariant: random wr_data/wr_en/blank_lz for 10k cycles.
   - Required: the assertion "an_out is FF or one-hot-low" never fails.
   - Every idx transition is preceded by at least 1 all-FF cycle.
